// File: rtl/pc_fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: data width, FSM state encoding
// and a small address helper.
package pc_fetch_seq_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_VALID = 2'd3
    } fetch_state_e;

    // Converts a 30-bit word offset into a 32-bit byte offset.
    function automatic logic [XLEN-1:0] word_to_byte(input logic [29:0] word_off);
        return {word_off, 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_seq_next.sv
// Next-PC calculation applied when downstream accepts an instruction.
// A taken branch has priority over a jump; a jump target is forced word
// aligned and flags misalignment of the requested target.
module pc_next_calc
    import pc_fetch_seq_pkg::*;
#(
    parameter int PC_STEP = 4
) (
    input  logic [XLEN-1:0] instr_pc,
    input  logic            br_taken,
    input  logic [29:0]     br_offset,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    logic [XLEN-1:0] seq_pc_s;

    assign seq_pc_s = instr_pc + STEP;

    // Select the redirect target: branch, then jump, then sequential.
    always_comb begin
        next_pc  = seq_pc_s;
        misalign = 1'b0;
        if (br_taken) begin
            next_pc  = seq_pc_s + word_to_byte(br_offset);
            misalign = 1'b0;
        end else if (jump) begin
            next_pc  = {jump_target[XLEN-1:2], 2'b00};
            misalign = (jump_target[1:0] != 2'b00);
        end else begin
            next_pc  = seq_pc_s;
            misalign = 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_seq.sv
// Fetch sequencer: owns the program counter, issues one instruction-memory
// request per instruction, holds the returned word for downstream, and
// applies branch/jump redirects when downstream accepts.
module pc_fetch_seq
    import pc_fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4,
    parameter int          TIMEOUT  = 16
) (
    input  logic        Clk,
    input  logic        ReSet_n,
    input  logic        Run,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRvalid,
    input  logic [31:0] ImemRdata,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [31:0] InstrPc,
    input  logic        InstrReady,
    input  logic        BrTaken,
    input  logic [31:0] BrOffset,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic        Misalign,
    output logic        ImemTimeout,
    output logic        Busy
);

    // Wait counter is wide enough for any practical TIMEOUT (up to 65536).
    localparam int              CNT_W     = 16;
    localparam logic            TO_EN     = (TIMEOUT != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

    fetch_state_e     state_r, state_s;
    logic [XLEN-1:0]  pc_r, pc_s;
    logic [XLEN-1:0]  instr_r, instr_s;
    logic [XLEN-1:0]  instr_pc_r, instr_pc_s;
    logic [CNT_W-1:0] wait_cnt_r, wait_cnt_s;
    logic             timeout_r, timeout_s;
    logic             misalign_r, misalign_s;
    logic             req_r, valid_r, busy_r;

    logic [XLEN-1:0]  next_pc_s;
    logic             calc_misalign_s;
    logic             unused_s;

    // Only the low 30 bits of the branch offset take part in the target.
    assign unused_s = ^BrOffset[31:30];

    pc_next_calc #(
        .PC_STEP (PC_STEP)
    ) u_next (
        .instr_pc    (instr_pc_r),
        .br_taken    (BrTaken),
        .br_offset   (BrOffset[29:0]),
        .jump        (Jump),
        .jump_target (JumpTarget),
        .next_pc     (next_pc_s),
        .misalign    (calc_misalign_s)
    );

    // Next-state and datapath update for the fetch FSM.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        instr_s    = instr_r;
        instr_pc_s = instr_pc_r;
        wait_cnt_s = wait_cnt_r;
        timeout_s  = timeout_r;
        misalign_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Run) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ImemGnt) begin
                    state_s    = ST_WAIT;
                    wait_cnt_s = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (ImemRvalid) begin
                    instr_s    = ImemRdata;
                    instr_pc_s = pc_r;
                    state_s    = ST_VALID;
                end else if (TO_EN && (wait_cnt_r == CNT_LIMIT)) begin
                    // Retry the same address; the flag stays set until reset.
                    timeout_s = 1'b1;
                    state_s   = ST_REQ;
                end else begin
                    wait_cnt_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_VALID: begin
                if (InstrReady) begin
                    pc_s       = next_pc_s;
                    misalign_s = calc_misalign_s;
                    if (Run) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_VALID;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered output flags.
    always_ff @(posedge Clk or negedge ReSet_n) begin
        if (!ReSet_n) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            instr_r    <= 32'h0000_0000;
            instr_pc_r <= 32'h0000_0000;
            wait_cnt_r <= {CNT_W{1'b0}};
            timeout_r  <= 1'b0;
            misalign_r <= 1'b0;
            req_r      <= 1'b0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            instr_r    <= instr_s;
            instr_pc_r <= instr_pc_s;
            wait_cnt_r <= wait_cnt_s;
            timeout_r  <= timeout_s;
            // Misalign pulses in the cycle following the accepting edge.
            misalign_r <= misalign_s;
            req_r      <= (state_s == ST_REQ);
            valid_r    <= (state_s == ST_VALID);
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    assign ImemReq     = req_r;
    assign ImemAddr    = pc_r;
    assign InstrValid  = valid_r;
    assign Instr       = instr_r;
    assign InstrPc     = instr_pc_r;
    assign Misalign    = misalign_r;
    assign ImemTimeout = timeout_r;
    assign Busy        = busy_r;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed self-checking bench for pc_fetch_seq (TIMEOUT set to 4).
module tb_pc_fetch_seq;

    logic        Clk = 1'b0;
    logic        ReSet_n;
    logic        Run;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRvalid;
    logic [31:0] ImemRdata;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPc;
    logic        InstrReady;
    logic        BrTaken;
    logic [31:0] BrOffset;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        Misalign;
    logic        ImemTimeout;
    logic        Busy;

    int passed = 0;
    int total  = 0;

    localparam logic [31:0] K = 32'hA5A5_0000;

    pc_fetch_seq #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4),
        .TIMEOUT  (4)
    ) dut (
        .Clk         (Clk),
        .ReSet_n     (ReSet_n),
        .Run         (Run),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemGnt     (ImemGnt),
        .ImemRvalid  (ImemRvalid),
        .ImemRdata   (ImemRdata),
        .InstrValid  (InstrValid),
        .Instr       (Instr),
        .InstrPc     (InstrPc),
        .InstrReady  (InstrReady),
        .BrTaken     (BrTaken),
        .BrOffset    (BrOffset),
        .Jump        (Jump),
        .JumpTarget  (JumpTarget),
        .Misalign    (Misalign),
        .ImemTimeout (ImemTimeout),
        .Busy        (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Runs until InstrValid (bounded); memory returns exp_pc ^ K.
    task automatic fetch_one(input logic [31:0] exp_pc, output logic found);
        found     = 1'b0;
        ImemRdata = exp_pc ^ K;
        Run       = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (InstrValid) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        ReSet_n = 1'b0; Run = 1'b0; ImemGnt = 1'b0; ImemRvalid = 1'b0;
        ImemRdata = 32'h0; InstrReady = 1'b0; BrTaken = 1'b0; Jump = 1'b0;
        BrOffset = 32'h0; JumpTarget = 32'h0;
        step(); step();
        total++;
        if ({ImemReq, InstrValid, Misalign, ImemTimeout, Busy} !== 5'b00000)
            $display("FAIL reset_flags: got %b want 00000", {ImemReq, InstrValid, Misalign, ImemTimeout, Busy});
        else passed++;
        total++;
        if ({ImemAddr, Instr, InstrPc} !== 96'h0)
            $display("FAIL reset_data: addr %h instr %h pc %h want all 0", ImemAddr, Instr, InstrPc);
        else passed++;
        ReSet_n = 1'b1;
        step();
        total++;
        if ({Busy, ImemReq} !== 2'b00)
            $display("FAIL idle_no_run: busy/req %b want 00", {Busy, ImemReq});
        else passed++;
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        ImemGnt = 1'b1; ImemRvalid = 1'b1; InstrReady = 1'b1; Run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i) * 32'd4;
            ImemRdata = a ^ K;
            step();
            total++;
            if ({ImemReq, InstrValid, Busy, ImemAddr} !== {3'b101, a})
                $display("FAIL seq_req%0d: req/val/busy %b addr %h want 101 %h", i, {ImemReq, InstrValid, Busy}, ImemAddr, a);
            else passed++;
            step();
            total++;
            if ({ImemReq, InstrValid} !== 2'b00)
                $display("FAIL seq_wait%0d: req/val %b want 00", i, {ImemReq, InstrValid});
            else passed++;
            step();
            total++;
            if ({InstrValid, InstrPc, Instr} !== {1'b1, a, a ^ K})
                $display("FAIL seq_valid%0d: val %b pc %h instr %h want 1 %h %h", i, InstrValid, InstrPc, Instr, a, a ^ K);
            else passed++;
        end
        Run = 1'b0;
        step();
        total++;
        if ({Busy, InstrValid, ImemReq, ImemAddr} !== {3'b000, 32'h0000_000C})
            $display("FAIL seq_stop: flags %b addr %h want 000 0000000c", {Busy, InstrValid, ImemReq}, ImemAddr);
        else passed++;
    endtask

    task automatic test_branch();
        logic f;
        fetch_one(32'h0000_000C, f);
        total++;
        if ({f, InstrPc} !== {1'b1, 32'h0000_000C})
            $display("FAIL br_fetch_c: found %b pc %h want 1 0000000c", f, InstrPc);
        else passed++;
        step();
        total++;
        if ({ImemReq, ImemAddr} !== {1'b1, 32'h0000_0010})
            $display("FAIL br_seq_next: req %b addr %h want 1 00000010", ImemReq, ImemAddr);
        else passed++;
        fetch_one(32'h0000_0010, f);
        BrTaken = 1'b1; BrOffset = 32'h0000_0003;
        step();
        BrTaken = 1'b0;
        total++;
        if ({f, ImemAddr} !== {1'b1, 32'h0000_0020})
            $display("FAIL br_fwd: found %b addr %h want 1 00000020", f, ImemAddr);
        else passed++;
        fetch_one(32'h0000_0020, f);
        BrTaken = 1'b1; BrOffset = 32'hFFFF_FFFE;
        step();
        BrTaken = 1'b0;
        total++;
        if ({f, ImemAddr} !== {1'b1, 32'h0000_001C})
            $display("FAIL br_back: found %b addr %h want 1 0000001c", f, ImemAddr);
        else passed++;
    endtask

    task automatic test_jump();
        logic f;
        fetch_one(32'h0000_001C, f);
        Jump = 1'b1; JumpTarget = 32'h0000_0103;
        step();
        Jump = 1'b0;
        total++;
        if ({f, Misalign, ImemAddr} !== {2'b11, 32'h0000_0100})
            $display("FAIL jmp_mis: found/mis %b addr %h want 11 00000100", {f, Misalign}, ImemAddr);
        else passed++;
        step();
        total++;
        if (Misalign !== 1'b0)
            $display("FAIL jmp_mis_pulse: mis %b want 0", Misalign);
        else passed++;
        fetch_one(32'h0000_0100, f);
        BrTaken = 1'b1; BrOffset = 32'h0000_0001; Jump = 1'b1; JumpTarget = 32'h0000_0203;
        Run = 1'b0;
        step();
        BrTaken = 1'b0; Jump = 1'b0;
        total++;
        if ({f, Misalign, Busy, ImemAddr} !== {3'b100, 32'h0000_0108})
            $display("FAIL jmp_br_prio: found/mis/busy %b addr %h want 100 00000108", {f, Misalign, Busy}, ImemAddr);
        else passed++;
    endtask

    task automatic test_timeout();
        ImemRvalid = 1'b0; ImemRdata = 32'h0000_0108 ^ K; Run = 1'b1;
        step();
        total++;
        if ({ImemReq, ImemAddr} !== {1'b1, 32'h0000_0108})
            $display("FAIL to_req: req %b addr %h want 1 00000108", ImemReq, ImemAddr);
        else passed++;
        step();
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({ImemReq, ImemTimeout, Busy, InstrValid} !== 4'b0010)
                $display("FAIL to_wait%0d: req/to/busy/val %b want 0010", k, {ImemReq, ImemTimeout, Busy, InstrValid});
            else passed++;
            step();
        end
        total++;
        if ({ImemReq, ImemTimeout, ImemAddr} !== {2'b11, 32'h0000_0108})
            $display("FAIL to_retry: req/to %b addr %h want 11 00000108", {ImemReq, ImemTimeout}, ImemAddr);
        else passed++;
        ImemGnt = 1'b0; ImemRvalid = 1'b1;
        step();
        total++;
        if ({ImemReq, InstrValid} !== 2'b10)
            $display("FAIL to_late_rvalid: req/val %b want 10", {ImemReq, InstrValid});
        else passed++;
        ImemGnt = 1'b1; ImemRvalid = 1'b0;
        step();
        ImemRvalid = 1'b1;
        step();
        total++;
        if ({InstrValid, ImemTimeout, InstrPc, Instr} !== {2'b11, 32'h0000_0108, 32'h0000_0108 ^ K})
            $display("FAIL to_deliver: val/to %b pc %h instr %h want 11 00000108 %h", {InstrValid, ImemTimeout}, InstrPc, Instr, 32'h0000_0108 ^ K);
        else passed++;
    endtask

    task automatic test_stall();
        InstrReady = 1'b0; BrTaken = 1'b1; BrOffset = 32'h0000_0005;
        Jump = 1'b1; JumpTarget = 32'h0000_0041;
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if ({InstrValid, ImemReq, Misalign, InstrPc, Instr} !== {3'b100, 32'h0000_0108, 32'h0000_0108 ^ K})
                $display("FAIL stall%0d: val/req/mis %b pc %h instr %h want 100 00000108", k, {InstrValid, ImemReq, Misalign}, InstrPc, Instr);
            else passed++;
        end
        BrTaken = 1'b0; Jump = 1'b0; InstrReady = 1'b1; Run = 1'b0;
        step();
        total++;
        if ({Busy, InstrValid, ImemReq, ImemAddr} !== {3'b000, 32'h0000_010C})
            $display("FAIL stall_idle: flags %b addr %h want 000 0000010c", {Busy, InstrValid, ImemReq}, ImemAddr);
        else passed++;
        step();
        total++;
        if ({Busy, ImemReq} !== 2'b00)
            $display("FAIL stall_stay_idle: busy/req %b want 00", {Busy, ImemReq});
        else passed++;
    endtask

    task automatic test_reset_in_wait();
        logic f;
        ImemRvalid = 1'b0; Run = 1'b1;
        step(); step();
        total++;
        if ({Busy, ImemReq, ImemTimeout} !== 3'b101)
            $display("FAIL rw_in_wait: busy/req/to %b want 101", {Busy, ImemReq, ImemTimeout});
        else passed++;
        #2 ReSet_n = 1'b0;
        #1;
        total++;
        if ({ImemReq, InstrValid, Misalign, ImemTimeout, Busy, ImemAddr, Instr, InstrPc} !== {5'b00000, 96'h0})
            $display("FAIL rw_async_clear: flags %b addr %h instr %h pc %h want 00000 0 0 0",
                     {ImemReq, InstrValid, Misalign, ImemTimeout, Busy}, ImemAddr, Instr, InstrPc);
        else passed++;
        Run = 1'b0; ImemRvalid = 1'b1;
        #2 ReSet_n = 1'b1;
        step(); step();
        total++;
        if ({Busy, InstrValid, ImemAddr} !== {2'b00, 32'h0000_0000})
            $display("FAIL rw_stale_rvalid: busy/val %b addr %h want 00 00000000", {Busy, InstrValid}, ImemAddr);
        else passed++;
        fetch_one(32'h0000_0000, f);
        total++;
        if ({f, InstrPc, Instr} !== {1'b1, 32'h0000_0000, K})
            $display("FAIL rw_refetch: found %b pc %h instr %h want 1 00000000 %h", f, InstrPc, Instr, K);
        else passed++;
        Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
        step();
        Jump = 1'b0;
        total++;
        if ({Misalign, ImemAddr} !== {1'b0, 32'hFFFF_FFFC})
            $display("FAIL wrap_jump: mis %b addr %h want 0 fffffffc", Misalign, ImemAddr);
        else passed++;
        fetch_one(32'hFFFF_FFFC, f);
        step();
        total++;
        if ({f, ImemReq, ImemAddr} !== {2'b11, 32'h0000_0000})
            $display("FAIL wrap_seq: found/req %b addr %h want 11 00000000", {f, ImemReq}, ImemAddr);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_timeout();
        test_stall();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
